// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-ported dmem.
// Checks faults when the request is latched and returns a one-cycle response to the owner.
module dmem_arbiter #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_rw,
    input  logic [2:0]  m0_funct3,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_resp_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic [3:0]  m0_err_code,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_rw,
    input  logic [2:0]  m1_funct3,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_resp_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [3:0]  m1_err_code,
    output logic        mem_rw,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exception
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    function automatic logic access_fault(input logic rw, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        if (rw) begin
            case (f3)
                3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
                default:                bad_f3 = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_f3 = 1'b0;
                default:                                bad_f3 = 1'b1;
            endcase
        end
        return bad_f3 || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    endfunction

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        grant_s, idle_s, hs_s;
    logic        owner_q, rw_q, fault_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  resp_valid_q, err_q, rdata_sel_q;
    logic [3:0]  code0_q, code1_q;
    logic        err_s;
    logic [3:0]  code_s;

    // Round-robin grant: on a tie the port not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            grant_s = ~last_grant_q;
        end else if (m1_req_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign idle_s       = (state_q == IDLE);
    assign m0_req_ready = idle_s && m0_req_valid && !grant_s;
    assign m1_req_ready = idle_s && m1_req_valid && grant_s;
    assign hs_s         = m0_req_ready || m1_req_ready;

    // Next-state logic for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request and its access-fault verdict at handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rw_q         <= 1'b0;
            fault_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
        end else if (hs_s) begin
            last_grant_q <= grant_s;
            owner_q      <= grant_s;
            rw_q         <= grant_s ? m1_rw : m0_rw;
            funct3_q     <= grant_s ? m1_funct3 : m0_funct3;
            addr_q       <= grant_s ? m1_addr : m0_addr;
            wdata_q      <= grant_s ? m1_wdata : m0_wdata;
            fault_q      <= grant_s ? access_fault(m1_rw, m1_funct3, m1_addr)
                                    : access_fault(m0_rw, m0_funct3, m0_addr);
        end else begin
            last_grant_q <= last_grant_q;
            owner_q      <= owner_q;
            rw_q         <= rw_q;
            fault_q      <= fault_q;
            funct3_q     <= funct3_q;
            addr_q       <= addr_q;
            wdata_q      <= wdata_q;
        end
    end

    // Memory drive: only ISSUE performs a real access; other cycles are an idle word read.
    always_comb begin
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        if (state_q == ISSUE) begin
            mem_rw     = rw_q & ~fault_q;
            mem_funct3 = funct3_q;
        end else begin
            mem_rw     = 1'b0;
            mem_funct3 = 3'b010;
        end
    end

    // Fault classification; an access fault outranks misalignment.
    always_comb begin
        err_s = fault_q | mem_exception;
        if (fault_q) begin
            code_s = rw_q ? 4'd7 : 4'd5;
        end else if (mem_exception) begin
            code_s = rw_q ? 4'd6 : 4'd4;
        end else begin
            code_s = 4'd0;
        end
    end

    // Response registers, loaded on the ISSUE -> RESP edge and cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 2'b00;
            err_q        <= 2'b00;
            rdata_sel_q  <= 2'b00;
            code0_q      <= 4'd0;
            code1_q      <= 4'd0;
        end else if (state_q == ISSUE) begin
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            err_q        <= err_s ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            rdata_sel_q  <= (!rw_q && !err_s) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            code0_q      <= owner_q ? 4'd0 : code_s;
            code1_q      <= owner_q ? code_s : 4'd0;
        end else begin
            resp_valid_q <= 2'b00;
            err_q        <= 2'b00;
            rdata_sel_q  <= 2'b00;
            code0_q      <= 4'd0;
            code1_q      <= 4'd0;
        end
    end

    // dmem read data arrives during RESP, so it is gated by a registered select.
    assign m0_resp_valid = resp_valid_q[0];
    assign m1_resp_valid = resp_valid_q[1];
    assign m0_err        = err_q[0];
    assign m1_err        = err_q[1];
    assign m0_err_code   = code0_q;
    assign m1_err_code   = code1_q;
    assign m0_rdata      = rdata_sel_q[0] ? mem_rdata : 32'h0000_0000;
    assign m1_rdata      = rdata_sel_q[1] ? mem_rdata : 32'h0000_0000;

endmodule
